// File: rtl/q2_panel_loader.sv
// Front-panel program loader for the q2 core: turns a valid/ready word stream into timed
// deposit / increment-P pulses. Optional macro Q2_LOADER_AUTOSTART_EN adds a start pulse after the last word.
module q2_panel_loader #(
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [11:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        abort,
  output logic [11:0] sw,
  output logic        dep_sw,
  output logic        incp_sw,
  output logic        start_sw,
  output logic        stop_sw,
  output logic        busy,
  output logic        done,
  output logic [11:0] word_count
);

  localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, DEP, DEP_GAP, INC, INC_GAP, START, START_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [11:0]   sw_q, sw_d;
  logic [11:0]   wc_q, wc_d;
  logic          last_q, last_d;
  logic          dep_q, dep_d;
  logic          incp_q, incp_d;
  logic          start_q, start_d;
  logic          stop_q, stop_d;
  logic          done_q, done_d;
  logic          restart_q, restart_d;
  logic          timer_done;

  assign load_ready = (state_q == IDLE) && !abort;
  assign busy       = (state_q != IDLE);
  assign sw         = sw_q;
  assign dep_sw     = dep_q;
  assign incp_sw    = incp_q;
  assign start_sw   = start_q;
  assign stop_sw    = stop_q;
  assign done       = done_q;
  assign word_count = wc_q;
  assign timer_done = (timer_q == '0);

  // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_done ? timer_q : timer_q - 1'b1;
    sw_d      = sw_q;
    wc_d      = wc_q;
    last_d    = last_q;
    dep_d     = dep_q;
    incp_d    = incp_q;
    start_d   = start_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    restart_d = restart_q;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      timer_d = '0;
      dep_d   = 1'b0;
      incp_d  = 1'b0;
      start_d = 1'b0;
      stop_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready) begin
            sw_d    = load_data;
            last_d  = load_last;
            stop_d  = 1'b1;
            timer_d = T_SETUP;
            state_d = SETUP;
            // A new program after a completed one counts its words from zero.
            if (restart_q) begin
              wc_d      = '0;
              restart_d = 1'b0;
            end
          end
        end
        SETUP: if (timer_done) begin
          dep_d   = 1'b1;
          timer_d = T_PULSE;
          state_d = DEP;
        end
        DEP: if (timer_done) begin
          dep_d   = 1'b0;
          timer_d = T_GAP;
          state_d = DEP_GAP;
        end
        DEP_GAP: if (timer_done) begin
          incp_d  = 1'b1;
          timer_d = T_PULSE;
          state_d = INC;
        end
        INC: if (timer_done) begin
          incp_d  = 1'b0;
          timer_d = T_GAP;
          state_d = INC_GAP;
        end
        INC_GAP: if (timer_done) begin
          wc_d    = wc_q + 12'd1;
          state_d = IDLE;
          if (last_q) begin
            stop_d = 1'b0;
`ifdef Q2_LOADER_AUTOSTART_EN
            start_d = 1'b1;
            timer_d = T_PULSE;
            state_d = START;
`else
            done_d    = 1'b1;
            restart_d = 1'b1;
`endif
          end
        end
        START: if (timer_done) begin
          start_d = 1'b0;
          timer_d = T_GAP;
          state_d = START_GAP;
        end
        START_GAP: if (timer_done) begin
          done_d    = 1'b1;
          restart_d = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sw_q      <= '0;
      wc_q      <= '0;
      last_q    <= 1'b0;
      dep_q     <= 1'b0;
      incp_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sw_q      <= sw_d;
      wc_q      <= wc_d;
      last_q    <= last_d;
      dep_q     <= dep_d;
      incp_q    <= incp_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      restart_q <= restart_d;
    end
  end

endmodule

// File: tb/tb_q2_panel_loader.sv
// Self-checking bench for q2_panel_loader: a per-word timeline model (offsets from the transfer
// edge) is compared against every output on each falling edge, plus literal timing checks.
module tb_q2_panel_loader;

  localparam int S = 2;
  localparam int P = 4;
  localparam int G = 2;
  localparam int WORD_END = S + 2*P + 2*G;
`ifdef Q2_LOADER_AUTOSTART_EN
  localparam bit AUTO     = 1'b1;
  localparam int LOAD_END = WORD_END + P + G;
`else
  localparam bit AUTO     = 1'b0;
  localparam int LOAD_END = WORD_END;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic [11:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        abort = 1'b0;
  logic        load_ready, dep_sw, incp_sw, start_sw, stop_sw, busy, done;
  logic [11:0] sw, word_count;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  q2_panel_loader #(.SETUP_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .abort(abort), .sw(sw),
    .dep_sw(dep_sw), .incp_sw(incp_sw), .start_sw(start_sw), .stop_sw(stop_sw),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one word = a fixed timeline of offsets ----------------
  bit        m_active, m_last, m_stop, m_done, m_restart;
  int        m_off;
  logic [11:0] m_sw, m_wc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_last = 0; m_stop = 0; m_done = 0; m_restart = 0;
      m_off = 0; m_sw = '0; m_wc = '0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (abort) begin
          m_active = 0;
          m_stop = 0;
        end else begin
          m_off++;
          if (m_off == WORD_END) begin
            m_wc = m_wc + 12'd1;
            if (m_last) m_stop = 0;
          end
          if (m_off == (m_last ? LOAD_END : WORD_END)) begin
            m_active = 0;
            if (m_last) begin
              m_done = 1;
              m_restart = 1;
            end
          end
        end
      end else if (load_valid && !abort) begin
        m_active = 1; m_off = 0;
        m_sw = load_data; m_last = load_last; m_stop = 1;
        if (m_restart) begin
          m_wc = '0;
          m_restart = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("sw", sw, m_sw);
      check("dep_sw", dep_sw, m_active && m_off >= S && m_off < S + P);
      check("incp_sw", incp_sw, m_active && m_off >= S + P + G && m_off < S + 2*P + G);
      check("start_sw", start_sw, AUTO && m_active && m_off >= WORD_END && m_off < WORD_END + P);
      check("stop_sw", stop_sw, m_stop);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("word_count", word_count, m_wc);
      check("load_ready", load_ready, !m_active && !abort);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [11:0] d, input logic l);
    bit got = 0;
    @(posedge clk); #1;
    load_valid = 1; load_data = d; load_last = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (load_ready) begin
        @(posedge clk); #1;
        load_valid = 0;
        got = 1;
        break;
      end
    end
    check("accept_timeout", got, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    check("idle_timeout", ok, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_dep, dep_len, first_incp, incp_len, first_start, start_len, done_off;
    logic [11:0] sw0;
    logic stop13, stop14;
    int n, dep_rises, incp_rises, done_cnt;
    logic prev_dep, prev_incp, wrap_seen;
    logic [11:0] prev_wc;
    bit seen;

    // Reset
    #3 rst = 0;
    #1;
    check("rst_ready", load_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wc", word_count, 0);
    check("rst_sw", sw, 0);
    check("rst_stop", stop_sw, 0);
    #20 rst = 1;
    cmp_en = 1;

    // Single word 0xA5C, last
    send_word(12'hA5C, 1);
    first_dep = -1; first_incp = -1; first_start = -1; done_off = -1;
    dep_len = 0; incp_len = 0; start_len = 0; sw0 = '0; stop13 = 0; stop14 = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) sw0 = sw;
      if (dep_sw) begin if (first_dep < 0) first_dep = k; dep_len++; end
      if (incp_sw) begin if (first_incp < 0) first_incp = k; incp_len++; end
      if (start_sw) begin if (first_start < 0) first_start = k; start_len++; end
      if (done) done_off = k;
      if (k == 13) stop13 = stop_sw;
      if (k == 14) stop14 = stop_sw;
    end
    check("single_sw", sw0, 12'hA5C);
    check("single_dep_rise", first_dep, 2);
    check("single_dep_len", dep_len, 4);
    check("single_incp_rise", first_incp, 8);
    check("single_incp_len", incp_len, 4);
    check("single_stop13", stop13, 1);
    check("single_stop14", stop14, 0);
    check("single_wc", word_count, 1);
`ifdef Q2_LOADER_AUTOSTART_EN
    check("single_start_rise", first_start, 14);
    check("single_start_len", start_len, 4);
    check("single_done", done_off, 20);
`else
    check("single_start_len", start_len, 0);
    check("single_done", done_off, 14);
`endif

    // Stream of 3 words with load_valid held high
    @(posedge clk); #1;
    load_valid = 1; load_data = 12'($urandom); load_last = 0;
    n = 0; dep_rises = 0; incp_rises = 0; done_cnt = 0; prev_dep = 0; prev_incp = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (dep_sw && !prev_dep) dep_rises++;
      if (incp_sw && !prev_incp) incp_rises++;
      if (done) done_cnt++;
      prev_dep = dep_sw; prev_incp = incp_sw;
      if (load_ready && load_valid) begin
        n++;
        @(posedge clk); #1;
        if (n == 3) load_valid = 0;
        else begin
          load_data = 12'($urandom);
          load_last = (n == 2);
        end
      end
    end
    check("stream_accepts", n, 3);
    check("stream_dep_pulses", dep_rises, 3);
    check("stream_incp_pulses", incp_rises, 3);
    check("stream_done_pulses", done_cnt, 1);
    check("stream_wc", word_count, 3);

    // Abort one cycle after incp_sw rises on word 2
    send_word(12'($urandom), 0);
    wait_idle();
    send_word(12'($urandom), 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (incp_sw) begin seen = 1; break; end
    end
    check("abort_incp_seen", seen, 1);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    check("abort_incp", incp_sw, 0);
    check("abort_busy", busy, 0);
    check("abort_stop", stop_sw, 0);
    check("abort_wc", word_count, 1);

    // 4097 back-to-back non-last words: count wraps
    @(posedge clk); #1;
    load_valid = 1; load_data = 12'($urandom); load_last = 0;
    n = 0; wrap_seen = 0; prev_wc = word_count;
    for (int c = 0; c < 4097*15 + 100; c++) begin
      @(negedge clk);
      if (prev_wc == 12'hFFF && word_count == 12'h000) wrap_seen = 1;
      prev_wc = word_count;
      if (n == 4097 && !busy) break;
      if (load_ready && load_valid) begin
        n++;
        @(posedge clk); #1;
        if (n == 4097) load_valid = 0;
        else load_data = 12'($urandom);
      end
    end
    check("wrap_accepts", n, 4097);
    check("wrap_seen", wrap_seen, 1);
    check("wrap_wc", word_count, 2);

    // Randomised traffic with occasional aborts
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      load_valid = ($urandom % 3) != 0;
      load_data  = 12'($urandom);
      load_last  = ($urandom % 4) == 0;
      abort      = ($urandom % 25) == 0;
    end
    @(posedge clk); #1;
    load_valid = 0; abort = 0;
    wait_idle();

    // Reset in the middle of a deposit pulse
    send_word(12'($urandom), 1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dep_sw) begin seen = 1; break; end
    end
    check("mid_dep_seen", seen, 1);
    #2 rst = 0;
    #1;
    check("mid_rst_dep", dep_sw, 0);
    check("mid_rst_ready", load_ready, 1);
    check("mid_rst_wc", word_count, 0);
    check("mid_rst_stop", stop_sw, 0);
    @(negedge clk);
    #2 rst = 1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
